// File: rtl/dcache_pkg.sv
// Shared geometry and FSM state for the data cache.
// 8 lines x 4 words x 16 bits, direct-mapped, write-back.
package dcache_pkg;

  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES  = 8;
  localparam int TAG_W      = 11;
  localparam int IDX_W      = 3;
  localparam int OFF_W      = 2;
  localparam int WORD_W     = 16;
  localparam int LINE_W     = LINE_WORDS * WORD_W;
  localparam int ADDR_W     = TAG_W + IDX_W + OFF_W;

  typedef enum logic [1:0] {
    IDLE,
    WBACK,
    FILL
  } state_t;

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: one combinational read port,
// one synchronous write port (whole line on fill, one word on store).
module dcache_array
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [LINE_W-1:0] rd_line,
  input  logic              line_we,
  input  logic              word_we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line,
  input  logic [WORD_W-1:0] wr_word
);

  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [LINE_W-1:0]    data [NUM_LINES];

  assign rd_tag   = tags[rd_idx];
  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];
  assign rd_line  = data[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (line_we) begin
      valid[wr_idx] <= 1'b1;
      dirty[wr_idx] <= 1'b0;
    end else if (word_we) begin
      dirty[wr_idx] <= 1'b1;
    end
  end

  // Payload is left unreset; validity alone decides hits.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_line;
    end else if (word_we) begin
      data[wr_idx][int'(wr_off)*WORD_W +: WORD_W] <= wr_word;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller.
// Zero-wait hits in IDLE; misses walk WBACK (if dirty) then FILL.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    re,
  input  logic                    we,
  input  logic [WORD_W-1:0]       wrt_data,
  output logic [WORD_W-1:0]       rd_data,
  output logic                    d_rdy,
  output logic [TAG_W+IDX_W-1:0]  m_addr,
  output logic                    m_re,
  output logic                    m_we,
  output logic [LINE_W-1:0]       m_wr_data,
  input  logic [LINE_W-1:0]       m_rd_data,
  input  logic                    m_rdy
);

  state_t state;
  state_t nxt;

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [TAG_W-1:0]  miss_tag;
  logic [IDX_W-1:0]  miss_idx;
  logic [TAG_W-1:0]  st_tag;
  logic              st_valid;
  logic              st_dirty;
  logic [LINE_W-1:0] st_line;
  logic              req;
  logic              hit;
  logic              latch;
  logic              line_we;
  logic              word_we;

  assign off = addr[OFF_W-1:0];
  assign idx = addr[OFF_W+IDX_W-1:OFF_W];
  assign tag = addr[ADDR_W-1:OFF_W+IDX_W];
  assign req = re | we;

  // Outside IDLE the array must look at the latched line, not addr.
  assign rd_idx = (state == IDLE) ? idx : miss_idx;
  assign wr_idx = line_we ? miss_idx : idx;

  assign hit       = req & st_valid & (st_tag == tag);
  assign rd_data   = st_line[int'(off)*WORD_W +: WORD_W];
  assign m_wr_data = st_line;
  assign word_we   = d_rdy & we;

  dcache_array u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (rd_idx),
    .rd_tag   (st_tag),
    .rd_valid (st_valid),
    .rd_dirty (st_dirty),
    .rd_line  (st_line),
    .line_we  (line_we),
    .word_we  (word_we),
    .wr_idx   (wr_idx),
    .wr_off   (off),
    .wr_tag   (miss_tag),
    .wr_line  (m_rd_data),
    .wr_word  (wrt_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      miss_tag <= tag;
      miss_idx <= idx;
    end
  end

  always_comb begin
    nxt     = state;
    d_rdy   = 1'b0;
    m_re    = 1'b0;
    m_we    = 1'b0;
    m_addr  = {miss_tag, miss_idx};
    latch   = 1'b0;
    line_we = 1'b0;
    unique case (state)
      IDLE: begin
        if (hit) begin
          d_rdy = rst_n;
        end else if (req) begin
          latch = rst_n;
          nxt   = (st_valid && st_dirty) ? WBACK : FILL;
        end
      end
      WBACK: begin
        m_we   = rst_n;
        m_addr = {st_tag, miss_idx};
        if (m_rdy) nxt = FILL;
      end
      FILL: begin
        m_re = rst_n;
        if (m_rdy) begin
          line_we = rst_n;
          nxt     = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl against a word-level memory model.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic        re;
  logic        we;
  logic [15:0] wrt_data;
  logic [15:0] rd_data;
  logic        d_rdy;
  logic [13:0] m_addr;
  logic        m_re;
  logic        m_we;
  logic [63:0] m_wr_data;
  logic [63:0] m_rd_data;
  logic        m_rdy;

  int checks = 0;
  int failures = 0;

  // Backing memory (lines) and coherent view of latest stores (words).
  logic [63:0] bk   [logic [13:0]];
  logic [15:0] refw [logic [15:0]];
  // Residency model: which line occupies each set, and whether dirty.
  bit          mv [8];
  bit          md [8];
  logic [10:0] mt [8];

  dcache_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .re        (re),
    .we        (we),
    .wrt_data  (wrt_data),
    .rd_data   (rd_data),
    .d_rdy     (d_rdy),
    .m_addr    (m_addr),
    .m_re      (m_re),
    .m_we      (m_we),
    .m_wr_data (m_wr_data),
    .m_rd_data (m_rd_data),
    .m_rdy     (m_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(input logic [15:0] a);
    if (a[15:2] == 14'h0010) return {14'd0, a[1:0]} + 16'd1;
    return a ^ 16'hA5C3;
  endfunction

  function automatic logic [63:0] bk_line(input logic [13:0] la);
    logic [63:0] l;
    if (bk.exists(la)) return bk[la];
    for (int i = 0; i < 4; i++) l[i*16 +: 16] = init_word({la, 2'(i)});
    return l;
  endfunction

  function automatic logic [15:0] rv(input logic [15:0] a);
    logic [63:0] l;
    if (refw.exists(a)) return refw[a];
    l = bk_line(a[15:2]);
    return l[int'(a[1:0])*16 +: 16];
  endfunction

  function automatic logic [63:0] view_line(input logic [13:0] la);
    logic [63:0] l;
    for (int i = 0; i < 4; i++) l[i*16 +: 16] = rv({la, 2'(i)});
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    refw.delete();
  endtask

  task automatic access(input logic [15:0] a, input logic r, input logic w,
                        input logic [15:0] d, input int lat, input string nm);
    logic [2:0]  ix;
    logic [10:0] tg;
    logic        ehit;
    logic        ewb;
    logic [15:0] exp_rd;
    logic [15:0] got_rd;
    int          exp_cyc;
    int          cyc;
    int          rc;
    int          wc;
    bit          done;
    bit          saw_wb;
    bit          saw_fill;
    ix = a[4:2];
    tg = a[15:5];
    ehit = mv[ix] && (mt[ix] == tg);
    ewb = !ehit && mv[ix] && md[ix];
    exp_cyc = ehit ? 1 : (ewb ? 2 + 2*lat : 2 + lat);
    exp_rd = rv(a);
    got_rd = '0;
    addr = a; re = r; we = w; wrt_data = d;
    cyc = 0; rc = 0; wc = 0;
    done = 0; saw_wb = 0; saw_fill = 0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (m_re && m_we) begin
        failures++;
        $display("FAIL %s m_re_m_we: both high at cycle %0d", nm, cyc);
      end
      if (d_rdy) begin
        done = 1;
        got_rd = rd_data;
      end else if (m_we) begin
        wc++;
        if (wc == 1) begin
          saw_wb = 1;
          checks++;
          if (m_addr !== {mt[ix], ix}) begin
            failures++;
            $display("FAIL %s wb_addr: got %h want %h", nm, m_addr, {mt[ix], ix});
          end
          checks++;
          if (m_wr_data !== view_line({mt[ix], ix})) begin
            failures++;
            $display("FAIL %s wb_data: got %h want %h", nm, m_wr_data,
                     view_line({mt[ix], ix}));
          end
        end
        if (wc == lat) begin
          bk[m_addr] = m_wr_data;
          m_rdy = 1'b1;
        end
      end else if (m_re) begin
        rc++;
        if (rc == 1) begin
          saw_fill = 1;
          checks++;
          if (m_addr !== {tg, ix}) begin
            failures++;
            $display("FAIL %s fill_addr: got %h want %h", nm, m_addr, {tg, ix});
          end
        end
        m_rd_data = bk_line(m_addr);
        if (rc == lat) m_rdy = 1'b1;
      end
      @(posedge clk);
      #1;
      m_rdy = 1'b0;
    end
    re = 1'b0;
    we = 1'b0;
    checks++;
    if (cyc !== exp_cyc || !done) begin
      failures++;
      $display("FAIL %s latency: got %0d (done=%0d) want %0d", nm, cyc, done, exp_cyc);
    end
    checks++;
    if (saw_wb !== ewb || saw_fill !== !ehit) begin
      failures++;
      $display("FAIL %s traffic: got wb=%0d fill=%0d want wb=%0d fill=%0d",
               nm, saw_wb, saw_fill, ewb, !ehit);
    end
    if (r && !w) begin
      checks++;
      if (got_rd !== exp_rd) begin
        failures++;
        $display("FAIL %s rd_data: got %h want %h", nm, got_rd, exp_rd);
      end
    end
    if (!ehit) begin
      mv[ix] = 1'b1;
      mt[ix] = tg;
      md[ix] = 1'b0;
    end
    if (w) begin
      md[ix] = 1'b1;
      refw[a] = d;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    addr = 16'h0041; re = 1'b1; we = 1'b0; wrt_data = '0;
    m_rdy = 1'b0; m_rd_data = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (d_rdy !== 1'b0 || m_re !== 1'b0 || m_we !== 1'b0) begin
        failures++;
        $display("FAIL reset_outs: got d_rdy=%b m_re=%b m_we=%b want 000",
                 d_rdy, m_re, m_we);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    re = 1'b0;
    model_reset();
  endtask

  task automatic test_cold_read();
    access(16'h0041, 1'b1, 1'b0, 16'h0, 4, "cold_read");
  endtask

  task automatic test_store_load();
    access(16'h0041, 1'b0, 1'b1, 16'hBEEF, 2, "store_hit");
    access(16'h0041, 1'b1, 1'b0, 16'h0, 2, "load_hit");
    checks++;
    if (rv(16'h0041) !== 16'hBEEF) begin
      failures++;
      $display("FAIL model_store: got %h want beef", rv(16'h0041));
    end
  endtask

  task automatic test_writeback();
    access(16'h0061, 1'b1, 1'b0, 16'h0, 3, "dirty_miss");
    access(16'h0061, 1'b1, 1'b0, 16'h0, 3, "after_wb_hit");
    checks++;
    if (bk_line(14'h0010) !== 64'h0004_0003_BEEF_0001) begin
      failures++;
      $display("FAIL wb_line: got %h want 00040003beef0001", bk_line(14'h0010));
    end
  endtask

  task automatic test_clean_miss();
    access(16'h0021, 1'b1, 1'b0, 16'h0, 2, "clean_miss_idx0");
    access(16'h0088, 1'b1, 1'b0, 16'h0, 1, "clean_miss_idx2");
  endtask

  task automatic test_both_high();
    access(16'h0003, 1'b1, 1'b1, 16'h1234, 2, "re_we_store");
    access(16'h0003, 1'b1, 1'b0, 16'h0, 2, "re_we_reload");
  endtask

  task automatic test_reset_fill();
    int cyc;
    addr = 16'h0145; re = 1'b1; we = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!m_re && cyc < 10);
    checks++;
    if (!m_re) begin
      failures++;
      $display("FAIL rst_fill_start: got m_re=%b want 1", m_re);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    re = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (m_re !== 1'b0 || m_we !== 1'b0 || d_rdy !== 1'b0) begin
      failures++;
      $display("FAIL rst_fill_abort: got m_re=%b m_we=%b d_rdy=%b want 000",
               m_re, m_we, d_rdy);
    end
    @(posedge clk);
    #1;
    access(16'h0145, 1'b1, 1'b0, 16'h0, 2, "reload_after_rst");
  endtask

  task automatic test_withdraw();
    logic [15:0] a;
    int rc;
    int cyc;
    a = 16'h0110;
    addr = a; re = 1'b1; we = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    re = 1'b0;
    addr = 16'hFFFF;
    rc = 0; cyc = 0;
    while (rc < 3 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (m_re) begin
        rc++;
        checks++;
        if (m_addr !== {a[15:5], a[4:2]}) begin
          failures++;
          $display("FAIL withdraw_addr: got %h want %h", m_addr, {a[15:5], a[4:2]});
        end
        m_rd_data = bk_line(m_addr);
        if (rc == 3) m_rdy = 1'b1;
      end
      @(posedge clk);
      #1;
      m_rdy = 1'b0;
    end
    mv[a[4:2]] = 1'b1;
    mt[a[4:2]] = a[15:5];
    md[a[4:2]] = 1'b0;
    @(negedge clk);
    checks++;
    if (rc != 3 || m_re !== 1'b0 || d_rdy !== 1'b0) begin
      failures++;
      $display("FAIL withdraw_done: got fills=%0d m_re=%b d_rdy=%b want 3 0 0",
               rc, m_re, d_rdy);
    end
    m_rdy = 1'b1;
    @(posedge clk);
    #1;
    m_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (m_re !== 1'b0 || m_we !== 1'b0) begin
      failures++;
      $display("FAIL idle_m_rdy: got m_re=%b m_we=%b want 00", m_re, m_we);
    end
    @(posedge clk);
    #1;
    access(a, 1'b1, 1'b0, 16'h0, 2, "withdraw_hit");
  endtask

  task automatic test_random();
    logic [15:0] a;
    int op;
    for (int n = 0; n < 150; n++) begin
      a = {11'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3))};
      op = $urandom_range(0, 2);
      access(a, op != 1, op != 0, 16'($urandom), $urandom_range(1, 4), "random");
    end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_store_load();
    test_writeback();
    test_clean_miss();
    test_both_high();
    test_reset_fill();
    test_withdraw();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
